// File: rtl/rf_pkg.sv
// Shared types, default widths and the write-priority resolver for the
// multi-channel register file.
package rf_pkg;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_READ_PORTS    = 8;
    localparam int DEF_WRITE_PORTS   = 4;

    // The resolver works on a fixed maximum channel/address shape; callers
    // zero-extend their channels into it (padded channels are never valid).
    localparam int MAX_WRITE_PORTS = 16;
    localparam int MAX_ADDR_W      = 16;
    localparam int WIN_IDX_W       = 4;

    typedef logic [DEF_WORD_WIDTH-1:0]    word_t;
    typedef logic [DEF_ADDRESS_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic                 hit;
        logic [WIN_IDX_W-1:0] idx;
    } winner_t;

    // Highest-index valid channel addressing target wins.
    function automatic winner_t write_winner(
        input logic [MAX_WRITE_PORTS-1:0]                 valid,
        input logic [MAX_WRITE_PORTS-1:0][MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0]                      target
    );
        winner_t res;
        res = '0;
        for (int i = 0; i < MAX_WRITE_PORTS; i++) begin
            if (valid[i] && (addr[i] == target)) begin
                res.hit = 1'b1;
                res.idx = WIN_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve handshake, read hazards and the
// sticky stray-write flag, driven by the merged per-register write hits.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int READ_PORTS    = DEF_READ_PORTS,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     arst_i,
    input  logic [2**ADDRESS_WIDTH-1:0]              wr_hit_i,
    input  logic                                     rsv_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]                 rsv_addr_i,
    input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [READ_PORTS-1:0]                    rd_hazard_o,
    output logic                                     rsv_ready_o,
    output logic [2**ADDRESS_WIDTH-1:0]              busy_o,
    output logic                                     stray_write_o
);

    localparam int REGS = 2**ADDRESS_WIDTH;

    logic [REGS-1:0] busy;
    logic [REGS-1:0] busy_next;
    logic [REGS-1:0] rsv_set;
    logic            stray;

    // A write landing this cycle frees the register, so a reserve may chain on it.
    always_comb begin
        rsv_ready_o = arst_i & rsv_valid_i & (~busy[rsv_addr_i] | wr_hit_i[rsv_addr_i]);
        rsv_set     = '0;
        if (rsv_ready_o) begin
            rsv_set[rsv_addr_i] = 1'b1;
        end
        busy_next = (busy & ~wr_hit_i) | rsv_set;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            busy  <= '0;
            stray <= 1'b0;
        end else begin
            busy <= busy_next;
            if (|(wr_hit_i & ~busy)) begin
                stray <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_hazard_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_hazard_o[p] = arst_i & busy[rd_addr_i[p]]
                           & ~(BYPASS & wr_hit_i[rd_addr_i[p]]);
        end
    end

    assign busy_o        = busy;
    assign stray_write_o = stray;

endmodule

// File: rtl/rf_bypass_scoreboard.sv
// Multi-port register file with prioritised write merge, optional
// same-cycle write-to-read bypass and a busy scoreboard.
module rf_bypass_scoreboard
    import rf_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int READ_PORTS    = DEF_READ_PORTS,
    parameter int WRITE_PORTS   = DEF_WRITE_PORTS,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                                      clk_i,
    input  logic                                      arst_i,
    input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  rd_addr_i,
    output logic [READ_PORTS-1:0][WORD_WIDTH-1:0]     rd_data_o,
    output logic [READ_PORTS-1:0]                     rd_hazard_o,
    input  logic [WRITE_PORTS-1:0]                    wr_valid_i,
    input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]    wr_data_i,
    input  logic                                      rsv_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]                  rsv_addr_i,
    output logic                                      rsv_ready_o,
    output logic [2**ADDRESS_WIDTH-1:0]               busy_o,
    output logic                                      stray_write_o
);

    localparam int REGS = 2**ADDRESS_WIDTH;
    localparam int CH_W = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

    logic [MAX_WRITE_PORTS-1:0]                 wv_ext;
    logic [MAX_WRITE_PORTS-1:0][MAX_ADDR_W-1:0] wa_ext;
    logic [REGS-1:0]                            wr_hit;
    logic [REGS-1:0][CH_W-1:0]                  wr_sel;
    logic [REGS-1:0][WORD_WIDTH-1:0]            regs;
    winner_t                                    win;

    always_comb begin
        wv_ext = '0;
        wa_ext = '0;
        for (int c = 0; c < WRITE_PORTS; c++) begin
            wv_ext[c] = wr_valid_i[c];
            wa_ext[c] = MAX_ADDR_W'(wr_addr_i[c]);
        end
    end

    // Resolve the winning channel once per register; reads and storage share it.
    always_comb begin
        wr_hit = '0;
        wr_sel = '0;
        win    = '0;
        for (int r = 0; r < REGS; r++) begin
            win       = write_winner(wv_ext, wa_ext, MAX_ADDR_W'(r));
            wr_hit[r] = win.hit;
            wr_sel[r] = CH_W'(win.idx);
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data_i[wr_sel[r]];
                end
            end
        end
    end

    // Reset forces reads to zero even if a write is on the channels.
    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (arst_i) begin
                if (BYPASS && wr_hit[rd_addr_i[p]]) begin
                    rd_data_o[p] = wr_data_i[wr_sel[rd_addr_i[p]]];
                end else begin
                    rd_data_o[p] = regs[rd_addr_i[p]];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .READ_PORTS    (READ_PORTS),
        .BYPASS        (BYPASS)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .wr_hit_i      (wr_hit),
        .rsv_valid_i   (rsv_valid_i),
        .rsv_addr_i    (rsv_addr_i),
        .rd_addr_i     (rd_addr_i),
        .rd_hazard_o   (rd_hazard_o),
        .rsv_ready_o   (rsv_ready_o),
        .busy_o        (busy_o),
        .stray_write_o (stray_write_o)
    );

endmodule

// File: tb/tb_rf_bypass_scoreboard.sv
// Bench for rf_bypass_scoreboard: BYPASS=1 and BYPASS=0 instances share stimulus
// and are checked every cycle against a behavioural register-file model.
module tb_rf_bypass_scoreboard;

    localparam int RP = 8;
    localparam int WP = 4;
    localparam int NR = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [RP-1:0][4:0]   rd_addr;
    logic [WP-1:0]        wr_valid;
    logic [WP-1:0][4:0]   wr_addr;
    logic [WP-1:0][31:0]  wr_data;
    logic                 rsv_valid;
    logic [4:0]           rsv_addr;

    logic [RP-1:0][31:0]  rd_data_b, rd_data_n;
    logic [RP-1:0]        hazard_b, hazard_n;
    logic                 ready_b, ready_n;
    logic [NR-1:0]        busy_b, busy_n;
    logic                 stray_b, stray_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_bypass_scoreboard #(.BYPASS(1'b1)) dut_b (
        .clk_i(clk), .arst_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_hazard_o(hazard_b), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
        .rsv_ready_o(ready_b), .busy_o(busy_b), .stray_write_o(stray_b)
    );

    rf_bypass_scoreboard #(.BYPASS(1'b0)) dut_n (
        .clk_i(clk), .arst_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .rd_hazard_o(hazard_n), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
        .rsv_ready_o(ready_n), .busy_o(busy_n), .stray_write_o(stray_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [NR];
    logic [31:0] m_busy;
    logic        m_stray;

    // Channel that ends up writing register a this cycle, or -1.
    function automatic int winner(input int a);
        for (int c = WP - 1; c >= 0; c--) begin
            if (wr_valid[c] && (int'(wr_addr[c]) == a)) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_read(input int a, input bit bypass);
        int w;
        w = winner(a);
        if (bypass && w >= 0) return wr_data[w];
        return m_mem[a];
    endfunction

    function automatic logic exp_hazard(input int a, input bit bypass);
        return m_busy[a] && !(bypass && winner(a) >= 0);
    endfunction

    function automatic logic exp_ready();
        return rsv_valid && (!m_busy[rsv_addr] || winner(int'(rsv_addr)) >= 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) m_mem[r] <= '0;
            m_busy  <= '0;
            m_stray <= 1'b0;
        end else begin
            logic [31:0] nb;
            nb = m_busy;
            for (int r = 0; r < NR; r++) begin
                int w;
                w = winner(r);
                if (w >= 0) begin
                    m_mem[r] <= wr_data[w];
                    nb[r] = 1'b0;
                    if (!m_busy[r]) m_stray <= 1'b1;
                end
            end
            if (exp_ready()) nb[rsv_addr] = 1'b1;
            m_busy <= nb;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < RP; p++) begin
                chk("rst_rd_b", rd_data_b[p], 32'h0);
                chk("rst_rd_n", rd_data_n[p], 32'h0);
            end
            chk("rst_hazard", {hazard_b, hazard_n}, 32'h0);
            chk("rst_ready", {ready_b, ready_n}, 32'h0);
            chk("rst_busy", busy_b | busy_n, 32'h0);
            chk("rst_stray", {stray_b, stray_n}, 32'h0);
        end else begin
            for (int p = 0; p < RP; p++) begin
                chk("rd_b", rd_data_b[p], exp_read(int'(rd_addr[p]), 1'b1));
                chk("rd_n", rd_data_n[p], exp_read(int'(rd_addr[p]), 1'b0));
                chk("hz_b", 32'(hazard_b[p]), 32'(exp_hazard(int'(rd_addr[p]), 1'b1)));
                chk("hz_n", 32'(hazard_n[p]), 32'(exp_hazard(int'(rd_addr[p]), 1'b0)));
            end
            chk("ready_b", 32'(ready_b), 32'(exp_ready()));
            chk("ready_n", 32'(ready_n), 32'(exp_ready()));
            chk("busy_b", busy_b, m_busy);
            chk("busy_n", busy_n, m_busy);
            chk("stray_b", 32'(stray_b), 32'(m_stray));
            chk("stray_n", 32'(stray_n), 32'(m_stray));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_idle();
        wr_valid  = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic wr(input int ch, input logic [4:0] a, input logic [31:0] d);
        wr_valid[ch] = 1'b1;
        wr_addr[ch]  = a;
        wr_data[ch]  = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_valid = 1'b1;
        rsv_addr  = a;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("lit_reset_busy", busy_b, 32'h0);
        chk("lit_reset_stray", 32'(stray_b), 32'h0);

        next(); rsv(5'd7); rd_addr[1] = 5'd7; #2;
        chk("lit_rsv7_ready", 32'(ready_b), 32'h1);
        chk("lit_rsv7_nohz", 32'(hazard_b[1]), 32'h0);

        next(); rsv(5'd5); #2;
        chk("lit_busy7", 32'(busy_b[7]), 32'h1);
        chk("lit_hz7_b", 32'(hazard_b[1]), 32'h1);
        chk("lit_hz7_n", 32'(hazard_n[1]), 32'h1);

        next(); wr(0, 5'd5, 32'h11); wr(3, 5'd5, 32'h33); rd_addr[0] = 5'd5; #2;
        chk("lit_coll_byp", rd_data_b[0], 32'h33);
        chk("lit_coll_nobyp", rd_data_n[0], 32'h0);
        chk("lit_coll_hz_b", 32'(hazard_b[0]), 32'h0);
        chk("lit_coll_hz_n", 32'(hazard_n[0]), 32'h1);

        next(); wr(1, 5'd7, 32'hAB); #2;
        chk("lit_r7_byp", rd_data_b[1], 32'hAB);
        chk("lit_r7_hz_b", 32'(hazard_b[1]), 32'h0);
        chk("lit_r5_stored", rd_data_n[0], 32'h33);
        chk("lit_busy5_clr", 32'(busy_b[5]), 32'h0);

        next(); #2;
        chk("lit_busy7_clr", 32'(busy_b[7]), 32'h0);
        chk("lit_r7_stored", rd_data_n[1], 32'hAB);
        chk("lit_no_stray", 32'(stray_b), 32'h0);

        next(); rsv(5'd3); #2;
        chk("lit_rsv3_ready", 32'(ready_b), 32'h1);
        next(); rsv(5'd3); #2;
        chk("lit_rsv3_refused", 32'(ready_b), 32'h0);
        next(); #2;
        chk("lit_busy3_held", 32'(busy_b[3]), 32'h1);
        next(); rsv(5'd3); wr(2, 5'd3, 32'h77); #2;
        chk("lit_rsv3_with_wr", 32'(ready_b), 32'h1);

        next(); rsv(5'd2); rd_addr[2] = 5'd3; #2;
        chk("lit_busy3_set_wins", 32'(busy_b[3]), 32'h1);
        chk("lit_r3_data", rd_data_n[2], 32'h77);
        chk("lit_stray_still0", 32'(stray_b), 32'h0);

        next(); wr(0, 5'd2, 32'h5); rd_addr[3] = 5'd2; #2;
        chk("lit_nobyp_old", rd_data_n[3], 32'h0);
        chk("lit_nobyp_hz", 32'(hazard_n[3]), 32'h1);
        chk("lit_byp_new", rd_data_b[3], 32'h5);
        next(); #2;
        chk("lit_nobyp_new", rd_data_n[3], 32'h5);

        next(); wr(0, 5'd9, 32'h99); rd_addr[4] = 5'd9; #2;
        chk("lit_stray_same_cyc", 32'(stray_b), 32'h0);
        next(); #2;
        chk("lit_stray_set", 32'(stray_b), 32'h1);
        next(); #2;
        chk("lit_stray_sticky", 32'(stray_n), 32'h1);

        // Asynchronous reset in the middle of a cycle carrying a write and a reserve.
        next(); wr(1, 5'd9, 32'h1234); rsv(5'd4); #2;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_rd9", rd_data_b[4], 32'h0);
        chk("lit_arst_r3", rd_data_n[2], 32'h0);
        chk("lit_arst_busy", busy_b, 32'h0);
        chk("lit_arst_stray", 32'(stray_b), 32'h0);
        chk("lit_arst_ready", 32'(ready_b), 32'h0);
        next();
        rst_n = 1'b1;
        #2;
        chk("lit_post_rst_r9", rd_data_b[4], 32'h0);
        chk("lit_post_rst_busy4", 32'(busy_b[4]), 32'h0);

        // Mixed traffic on a narrow address range to force collisions and chains.
        for (int i = 0; i < 300; i++) begin
            next();
            for (int c = 0; c < WP; c++) begin
                if ($urandom_range(0, 2) == 0) wr(c, 5'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 1) == 0) rsv(5'($urandom_range(0, 7)));
            for (int p = 0; p < RP; p++) rd_addr[p] = 5'($urandom_range(0, 8));
        end

        next();
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
